mem_word_transfer_unit: RTL
===========================

Name: mem_word_transfer_unit

Overview:
- Parametrised multi-byte load/store sequencer between the register datapath and the byte-wide data memory.
- Replaces ad-hoc byte selection with a self-timed transfer:
  - A store splits a DATA_W word into 1/2/4/... bytes on consecutive addresses.
  - A load assembles bytes into a DATA_W word.
- Supports configurable endianness, optional sign extension and configurable memory read latency.
- Sits beside the data register; the control unit issues Start and waits for Done.

Parameters:
- DATA_W, 32, word width in bits; multiple of 8, 8..64.
- ADDR_W, 16, memory address width.
- BIG_ENDIAN, 0, 0: byte i maps to bits [8i+7:8i]; 1: byte i maps to the most significant byte of the transferred field first.
- RD_LAT, 1, memory read latency in cycles (1..4) from Mem_En/address cycle to Mem_RData valid.

Ports:
- Clock  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Start  in  1  request; accepted only in IDLE.
- Write  in  1  1 = store, 0 = load; sampled at accept.
- Size  in  2  transfer length = 2^Size bytes; sampled at accept.
- SignExt  in  1  load only: 1 = sign-extend, 0 = zero-extend; sampled at accept.
- BaseAddr  in  ADDR_W  first byte address; sampled at accept.
- WData  in  DATA_W  store data; sampled at accept.
- Busy  out  1  high from the cycle after accept through the Done cycle inclusive.
- Done  out  1  one-cycle completion pulse.
- Err  out  1  pulses with Done when the request was rejected.
- RData  out  DATA_W  assembled load result.
- Mem_Addr  out  ADDR_W  byte address.
- Mem_WData  out  8  byte to write.
- Mem_RData  in  8  byte read from memory.
- Mem_En  out  1  memory access enable, active high.
- Mem_WR  out  1  1 = write access; qualified by Mem_En.

Behaviour:
- Reset (Reset=0, asynchronous), taking effect immediately:
  - State goes to IDLE.
  - Busy, Done, Err, Mem_En and Mem_WR are 0.
  - Mem_Addr, Mem_WData and RData are 0.
  - An in-flight transfer is aborted; no further memory accesses occur; partially assembled data is discarded.
- States: IDLE, XFER, DRAIN, DONE.
- IDLE:
  - Start=1 at a rising edge (t0) accepts the request and latches Write, Size, SignExt, BaseAddr and WData.
  - Let N = 2^Size. If N > DATA_W/8, go to DONE with the error flag set.
  - Otherwise go to XFER with byte index i = 0.
- XFER:
  - One byte per cycle, cycles t0+1 .. t0+N.
  - Mem_En=1, Mem_WR=Write, Mem_Addr = BaseAddr + i, mod 2^ADDR_W (wraps from all-ones to 0).
  - Store: Mem_WData = byte selected per BIG_ENDIAN from the low N bytes of WData.
  - After i = N-1: a store goes to DONE; a load goes to DRAIN.
- Load capture:
  - The byte addressed in cycle k is captured from Mem_RData at the end of cycle k+RD_LAT into its endian position.
  - Capture is pipelined and overlaps with XFER.
- DRAIN:
  - Mem_En=0; wait until the last capture, at cycle t0+N+RD_LAT, then go to DONE.
- DONE:
  - Lasts one cycle: Done=1, Busy=1; Err=1 only for a rejected request; then return to IDLE.
  - Done cycle: load = t0+N+RD_LAT+1; store = t0+N+1; error = t0+1.
- RData:
  - Updated only on successful load completion (visible in the Done cycle).
  - Bits above 8N are filled with bit 8N-1 if SignExt=1, else 0.
  - Held stable until the next successful load.
  - Unchanged by stores and by errors.
- Start while Busy (including the Done cycle) is ignored; there is no queuing.
- Outside XFER, Mem_En=0 and Mem_WR=0. Mem_WData holds its last value (don't-care).
- Inputs other than Start may change freely after accept without effect.

Test Plan:
- Setup for loads: RD_LAT=1, memory[0x0010..0x0013] = 11,22,33,44.
- Little-endian load, Size=1 at 0x0010:
  - Mem_En in t0+1..t0+2 with Mem_Addr 0x0010, 0x0011.
  - Done at t0+4; RData = 0x00002211; Busy high t0+1..t0+4.
- Big-endian load (BIG_ENDIAN=1), Size=2 at 0x0010:
  - RData = 0x11223344; Done at t0+6.
- Sign-extended byte load: memory[0x0020]=0x80, Size=0, SignExt=1:
  - RData = 0xFFFFFF80.
  - Same access with SignExt=0 gives 0x00000080.
- Little-endian store, Size=2, WData 0xA1B2C3D4 at BaseAddr 0xFFFE:
  - Writes D4@0xFFFE, C3@0xFFFF, B2@0x0000, A1@0x0001 (address wrap).
  - Done at t0+5; RData unchanged.
- Error case: Size=3 with DATA_W=32:
  - Done=1 and Err=1 at t0+1; Mem_En never asserted; RData unchanged.
- Start re-asserted during XFER:
  - Ignored; only one transfer occurs.
- Reset mid-transfer: Reset=0 in t0+2 of a 4-byte load.
  - Busy, Mem_En and RData drop to 0 asynchronously; no Done pulse.
  - A new Start after Reset is released is accepted normally.

Source files
------------

// File: rtl/mem_word_transfer_unit.sv
// Self-timed multi-byte load/store sequencer between a DATA_W register and a
// byte-wide data memory. Stores split a word into 2^Size bytes on consecutive
// addresses; loads reassemble them with optional sign extension.
module mem_word_transfer_unit #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 16,
  parameter int BIG_ENDIAN = 0,
  parameter int RD_LAT     = 1
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Write,
  input  logic [1:0]        Size,
  input  logic              SignExt,
  input  logic [ADDR_W-1:0] BaseAddr,
  input  logic [DATA_W-1:0] WData,
  output logic              Busy,
  output logic              Done,
  output logic              Err,
  output logic [DATA_W-1:0] RData,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [7:0]        Mem_WData,
  input  logic [7:0]        Mem_RData,
  output logic              Mem_En,
  output logic              Mem_WR
);
  localparam int unsigned NB = DATA_W / 8;

  typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_e;

  state_e state_q, state_d;

  logic              write_q,   write_d;
  logic              sext_q,    sext_d;
  logic              err_q,     err_d;
  logic [3:0]        n_q,       n_d;
  logic [2:0]        idx_q,     idx_d;
  logic [2:0]        cap_idx_q, cap_idx_d;
  logic [DATA_W-1:0] wdata_q,   wdata_d;
  logic [DATA_W-1:0] acc_q,     acc_d;
  logic [DATA_W-1:0] rdata_q,   rdata_d;
  logic [ADDR_W-1:0] addr_q,    addr_d;
  logic [7:0]        wbyte_q,   wbyte_d;
  logic [RD_LAT-1:0] pipe_q,    pipe_d;

  logic       accept;
  logic       err_new;
  logic [3:0] n_new;
  logic       last_issue;
  logic       capture;
  logic       last_capture;

  // Word byte lane occupied by transfer byte i of an n-byte field.
  function automatic logic [3:0] byte_pos(input logic [3:0] n, input logic [2:0] i);
    if (BIG_ENDIAN != 0) byte_pos = n - 4'd1 - {1'b0, i};
    else                 byte_pos = {1'b0, i};
  endfunction

  function automatic logic [7:0] get_byte(input logic [DATA_W-1:0] w, input logic [3:0] pos);
    get_byte = '0;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) == pos) get_byte = w[8*b +: 8];
  endfunction

  function automatic logic [DATA_W-1:0] put_byte(input logic [DATA_W-1:0] w,
                                                 input logic [3:0] pos,
                                                 input logic [7:0] v);
    put_byte = w;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) == pos) put_byte[8*b +: 8] = v;
  endfunction

  // Fill the lanes above the n-byte field with its top bit or with zeros.
  function automatic logic [DATA_W-1:0] sign_fill(input logic [DATA_W-1:0] w,
                                                  input logic [3:0] n,
                                                  input logic sx);
    logic sign;
    sign = 1'b0;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) == n - 4'd1) sign = w[8*b+7];
    sign_fill = w;
    for (int unsigned b = 0; b < NB; b++)
      if (4'(b) >= n) sign_fill[8*b +: 8] = {8{sx & sign}};
  endfunction

  // Request decode and byte-sequencing conditions.
  always_comb begin
    n_new        = 4'd1 << Size;
    accept       = (state_q == IDLE) && Start;
    err_new      = (32'(n_new) > NB);
    last_issue   = ({1'b0, idx_q} == n_q - 4'd1);
    capture      = pipe_q[RD_LAT-1];
    last_capture = capture && ({1'b0, cap_idx_q} == n_q - 4'd1);
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = err_new ? DONE : XFER;
      XFER:    if (last_issue) state_d = write_q ? DONE : DRAIN;
      DRAIN:   if (last_capture) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state; memory address/data and result come from flops.
  always_comb begin
    Busy      = (state_q != IDLE);
    Done      = (state_q == DONE);
    Err       = (state_q == DONE) && err_q;
    Mem_En    = (state_q == XFER);
    Mem_WR    = (state_q == XFER) && write_q;
    Mem_Addr  = addr_q;
    Mem_WData = wbyte_q;
    RData     = rdata_q;
  end

  // Request latch, address/store-byte stepping and pipelined load capture.
  // pipe_q tracks in-flight read issues so each returning byte lands in order;
  // the final capture feeds RData directly so the result is visible in DONE.
  always_comb begin
    write_d   = write_q;
    sext_d    = sext_q;
    err_d     = err_q;
    n_d       = n_q;
    idx_d     = idx_q;
    cap_idx_d = cap_idx_q;
    wdata_d   = wdata_q;
    acc_d     = acc_q;
    rdata_d   = rdata_q;
    addr_d    = addr_q;
    wbyte_d   = wbyte_q;
    pipe_d    = pipe_q << 1;
    pipe_d[0] = (state_q == XFER) && !write_q;

    if (accept) begin
      write_d   = Write;
      sext_d    = SignExt;
      n_d       = n_new;
      err_d     = err_new;
      wdata_d   = WData;
      idx_d     = '0;
      cap_idx_d = '0;
      acc_d     = '0;
      if (!err_new) begin
        addr_d = BaseAddr;
        if (Write) wbyte_d = get_byte(WData, byte_pos(n_new, 3'd0));
      end
    end

    if ((state_q == XFER) && !last_issue) begin
      idx_d  = idx_q + 3'd1;
      addr_d = addr_q + ADDR_W'(1);
      if (write_q) wbyte_d = get_byte(wdata_q, byte_pos(n_q, idx_q + 3'd1));
    end

    if (capture) begin
      acc_d     = put_byte(acc_q, byte_pos(n_q, cap_idx_q), Mem_RData);
      cap_idx_d = cap_idx_q + 3'd1;
      if (last_capture) rdata_d = sign_fill(acc_d, n_q, sext_q);
    end
  end

  // Datapath registers.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      write_q   <= 1'b0;
      sext_q    <= 1'b0;
      err_q     <= 1'b0;
      n_q       <= '0;
      idx_q     <= '0;
      cap_idx_q <= '0;
      wdata_q   <= '0;
      acc_q     <= '0;
      rdata_q   <= '0;
      addr_q    <= '0;
      wbyte_q   <= '0;
      pipe_q    <= '0;
    end else begin
      write_q   <= write_d;
      sext_q    <= sext_d;
      err_q     <= err_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      cap_idx_q <= cap_idx_d;
      wdata_q   <= wdata_d;
      acc_q     <= acc_d;
      rdata_q   <= rdata_d;
      addr_q    <= addr_d;
      wbyte_q   <= wbyte_d;
      pipe_q    <= pipe_d;
    end
  end

endmodule
